// File: rtl/sensor_fault_monitor_if.sv
// Bundle of the sensor pins, supervisor acknowledge and latched fault report.
// The master side is the supervisor/pins; the slave side is sensor_fault_monitor.
interface sensor_fault_monitor_if #(
  parameter int CNT_WIDTH = 8
);
  logic [3:0]           sensors;
  logic                 ack;
  logic                 fault;
  logic [3:0]           fault_code;
  logic [CNT_WIDTH-1:0] fault_count;

  modport master (
    output sensors, ack,
    input  fault, fault_code, fault_count
  );

  modport slave (
    input  sensors, ack,
    output fault, fault_code, fault_count
  );
endinterface

// File: rtl/sensor_fault_monitor.sv
// Synchronises the four sensor pins, debounces the error condition and latches a fault until acked.
// Optional feature: define SENSOR_FAULT_COUNT_EN to build the saturating fault_count counter.
module sensor_fault_monitor #(
  parameter int DEBOUNCE  = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  sensor_fault_monitor_if.slave bus
);

  localparam int DCW  = $clog2(DEBOUNCE + 1);
  localparam int DCW1 = DCW + 1;
  localparam logic [DCW:0] DEBOUNCE_V = DCW1'(DEBOUNCE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FAULT = 2'd2,
    CLEAR = 2'd3
  } state_t;

  state_t         state_reg;
  logic [3:0]     sync1_reg;
  logic [3:0]     sync2_reg;
  logic [DCW-1:0] cnt_reg;
  logic           fault_reg;
  logic [3:0]     fault_code_reg;

  logic           err_s;
  logic [DCW:0]   cnt_inc;
  logic           confirm;

  assign err_s   = sync2_reg[0] | (sync2_reg[1] & (sync2_reg[2] | sync2_reg[3]));
  assign cnt_inc = {1'b0, cnt_reg} + DCW1'(1);

  // A fault is confirmed on the edge that takes the FSM into FAULT.
  assign confirm = err_s &&
                   (((state_reg == IDLE) && (DEBOUNCE == 1)) ||
                    ((state_reg == PEND) && (cnt_inc == DEBOUNCE_V)));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_reg      <= 4'b0000;
      sync2_reg      <= 4'b0000;
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      fault_reg      <= 1'b0;
      fault_code_reg <= 4'b0000;
    end else begin
      sync1_reg <= bus.sensors;
      sync2_reg <= sync1_reg;

      case (state_reg)
        IDLE: begin
          if (!err_s) begin
            cnt_reg <= '0;
          end else if (confirm) begin
            state_reg      <= FAULT;
            fault_reg      <= 1'b1;
            fault_code_reg <= sync2_reg;
            cnt_reg        <= '0;
          end else begin
            state_reg <= PEND;
            cnt_reg   <= DCW'(1);
          end
        end

        PEND: begin
          if (!err_s) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (confirm) begin
            state_reg      <= FAULT;
            fault_reg      <= 1'b1;
            fault_code_reg <= sync2_reg;
            cnt_reg        <= '0;
          end else begin
            cnt_reg <= cnt_inc[DCW-1:0];
          end
        end

        FAULT: begin
          // A condition still present at ack time must go away before it can re-arm.
          if (bus.ack) begin
            fault_reg <= 1'b0;
            state_reg <= err_s ? CLEAR : IDLE;
          end
        end

        CLEAR: begin
          if (!err_s) begin
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
          fault_reg <= 1'b0;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign bus.fault      = fault_reg;
  assign bus.fault_code = fault_code_reg;

`ifdef SENSOR_FAULT_COUNT_EN
  logic [CNT_WIDTH-1:0] fault_count_reg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fault_count_reg <= '0;
    end else if (confirm && (fault_count_reg != {CNT_WIDTH{1'b1}})) begin
      fault_count_reg <= fault_count_reg + CNT_WIDTH'(1);
    end
  end

  assign bus.fault_count = fault_count_reg;
`else
  assign bus.fault_count = '0;
`endif

endmodule

// File: tb/tb_sensor_fault_monitor.sv
// Randomized and directed stimulus for two monitor instances (DEBOUNCE=4/CNT_WIDTH=8 and
// DEBOUNCE=1/CNT_WIDTH=2), each compared every cycle against a behavioural fault model.
module tb_sensor_fault_monitor;

  logic clk;
  logic n_rst;

  sensor_fault_monitor_if #(.CNT_WIDTH(8)) bus_a ();
  sensor_fault_monitor_if #(.CNT_WIDTH(2)) bus_b ();

  sensor_fault_monitor #(.DEBOUNCE(4), .CNT_WIDTH(8)) dut_a (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_a.slave)
  );

  sensor_fault_monitor #(.DEBOUNCE(1), .CNT_WIDTH(2)) dut_b (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Behavioural model: index 0 mirrors dut_a, index 1 mirrors dut_b.
  int         m_deb   [2];
  int         m_cmax  [2];
  logic [3:0] m_s1    [2];
  logic [3:0] m_s2    [2];
  int         m_run   [2];
  bit         m_latch [2];
  bit         m_block [2];
  logic [3:0] m_code  [2];
  int         m_count [2];

  logic [3:0] cur_sensors;
  logic       cur_ack;

  function automatic bit is_error(input logic [3:0] p);
    int ones_hi;
    ones_hi = int'(p[2]) + int'(p[3]);
    return (p[0] == 1'b1) || ((p[1] == 1'b1) && (ones_hi > 0));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = 4'b0000;  m_s2[k] = 4'b0000;
      m_run[k] = 0;       m_latch[k] = 0;  m_block[k] = 0;
      m_code[k] = 4'b0000; m_count[k] = 0;
    end
  endtask

  task automatic model_edge(input int k);
    bit err;
    err = is_error(m_s2[k]);
    if (m_latch[k]) begin
      if (cur_ack) begin
        m_latch[k] = 0;
        m_block[k] = err;
      end
      m_run[k] = 0;
    end else if (m_block[k]) begin
      if (!err) m_block[k] = 0;
    end else if (err) begin
      m_run[k]++;
      if (m_run[k] >= m_deb[k]) begin
        m_latch[k] = 1;
        m_code[k]  = m_s2[k];
        m_run[k]   = 0;
        if (m_count[k] < m_cmax[k]) m_count[k]++;
      end
    end else begin
      m_run[k] = 0;
    end
    m_s2[k] = m_s1[k];
    m_s1[k] = cur_sensors;
  endtask

  task automatic check_all();
    int exp_a;
    int exp_b;
`ifdef SENSOR_FAULT_COUNT_EN
    exp_a = m_count[0];
    exp_b = m_count[1];
`else
    exp_a = 0;
    exp_b = 0;
`endif
    check("a.fault",       32'(bus_a.fault),       32'(m_latch[0]));
    check("a.fault_code",  32'(bus_a.fault_code),  32'(m_code[0]));
    check("a.fault_count", 32'(bus_a.fault_count), 32'(exp_a));
    check("b.fault",       32'(bus_b.fault),       32'(m_latch[1]));
    check("b.fault_code",  32'(bus_b.fault_code),  32'(m_code[1]));
    check("b.fault_count", 32'(bus_b.fault_count), 32'(exp_b));
  endtask

  task automatic drive(input logic [3:0] s, input logic a);
    cur_sensors   = s;
    cur_ack       = a;
    bus_a.sensors = s;  bus_a.ack = a;
    bus_b.sensors = s;  bus_b.ack = a;
  endtask

  // Apply inputs, take one rising edge, update the model and compare 1 time unit later.
  task automatic step(input logic [3:0] s, input logic a);
    drive(s, a);
    @(posedge clk);
    if (n_rst) begin
      model_edge(0);
      model_edge(1);
    end
    #1;
    check_all();
  endtask

  task automatic hold(input logic [3:0] s, input int n);
    for (int i = 0; i < n; i++) step(s, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_deb[0] = 4;  m_cmax[0] = 255;
    m_deb[1] = 1;  m_cmax[1] = 3;
    model_reset();
    n_rst = 1'b0;
    drive(4'b0000, 1'b0);
    @(posedge clk);
    #1;
    check_all();
    n_rst = 1'b1;

    // Basic fault with latency, then release.
    hold(4'b0000, 2);
    hold(4'b0001, 8);
    step(4'b0001, 1'b1);
    hold(4'b0000, 4);

    // Glitch rejection: 3 cycles rejected, 4 cycles confirmed.
    hold(4'b0110, 3);
    hold(4'b0000, 5);
    hold(4'b0110, 4);
    hold(4'b0000, 4);
    step(4'b0000, 1'b1);
    hold(4'b0000, 3);

    // Non-error patterns never fault.
    hold(4'b0010, 20);
    hold(4'b1100, 20);
    hold(4'b1000, 20);

    // Ack with a persisting condition, then re-trigger.
    hold(4'b1010, 8);
    step(4'b1010, 1'b1);
    hold(4'b1010, 10);
    hold(4'b0000, 3);
    hold(4'b1010, 8);
    step(4'b1010, 1'b1);
    step(4'b1010, 1'b1);
    hold(4'b0000, 4);

    // Asynchronous reset in the middle of a latched fault.
    hold(4'b0001, 8);
    #3;
    n_rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    hold(4'b0001, 8);
    step(4'b0001, 1'b1);
    hold(4'b0000, 4);

    // Repeated confirm/ack cycles exercise counter saturation.
    for (int r = 0; r < 5; r++) begin
      hold(4'b0001, 7);
      step(4'b0000, 1'b1);
      hold(4'b0000, 3);
    end

    // Randomized runs of patterns with occasional acknowledges.
    for (int r = 0; r < 600; r++) begin
      logic [3:0] pat;
      int len;
      pat = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        step(pat, ($urandom_range(0, 5) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
